voice_phase_gen: RTL and testbench
==================================

VOICE_PHASE_GEN -- requirements
Module: voice_phase_gen

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of time-multiplexed oscillator voices (power of two).
REQ-002 SHALL have parameter PHASE_W, default 32, width of each voice's phase accumulator and increment.
REQ-003 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle pulse at audio sample rate.
REQ-006 SHALL have port cfg_valid  input  1  config write request.
REQ-007 SHALL have port cfg_ready  output  1  config write can be accepted this cycle.
REQ-008 SHALL have port cfg_voice  input  log2(NUM_VOICES)  target voice.
REQ-009 SHALL have port cfg_incr  input  PHASE_W  phase increment per sample (unsigned).
REQ-010 SHALL have port cfg_gate  input  1  note on (1) / off (0).
REQ-011 SHALL have port idx_valid  output  1  idx/idx_voice/idx_gate valid this cycle.
REQ-012 SHALL have port idx_voice  output  log2(NUM_VOICES)  voice of current idx.
REQ-013 SHALL have port idx  output  16  waveform-LUT phase index, phase[PHASE_W-1:PHASE_W-16].
REQ-014 SHALL have port idx_gate  output  1  gate of voice idx_voice.
REQ-015 SHALL have port overrun  output  1  sticky: sample_tick arrived during a sweep.

Function
REQ-016 FSM SHALL have states IDLE and SWEEP; reset state IDLE.
REQ-017 IDLE + sample_tick SHALL go to SWEEP with voice counter 0; SWEEP SHALL visit voices 0..NUM_VOICES-1, one per cycle, then return to IDLE.
REQ-018 In the cycle after the cycle that visits voice v, idx_valid SHALL be 1, idx_voice=v, idx = pre-increment phase[v] upper 16 bits, idx_gate=gate[v] (all outputs registered).
REQ-019 First idx_valid SHALL occur exactly 2 cycles after the sample_tick cycle; idx_valid SHALL be high for exactly NUM_VOICES consecutive cycles per tick.
REQ-020 When voice v is visited with gate[v]=1, phase[v] SHALL become phase[v]+incr[v] modulo 2^PHASE_W (silent wrap); with gate[v]=0, phase[v] SHALL hold.
REQ-021 cfg_ready SHALL equal (state==IDLE && !sample_tick); a write occurs on cfg_valid && cfg_ready.
REQ-022 On write, incr[cfg_voice] SHALL take cfg_incr and gate[cfg_voice] SHALL take cfg_gate.
REQ-023 A write with cfg_gate=1 to a voice whose gate is 0 (note-on) SHALL clear phase[cfg_voice] to 0; a write with gate already 1 SHALL keep the phase (glide).
REQ-024 A write SHALL be visible to the next sweep started by a later sample_tick.
REQ-025 sample_tick while in SWEEP SHALL be ignored and SHALL set overrun to 1 until reset.
REQ-026 When idx_valid=0, idx, idx_voice and idx_gate SHALL be 0.

Reset
REQ-027 reset_n low SHALL asynchronously force: state IDLE, voice counter 0, all phase/incr/gate 0, idx_valid 0, idx 0, idx_voice 0, idx_gate 0, overrun 0; cfg_ready then follows REQ-021.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; no further idx_valid until a new sample_tick after release.

Structure
REQ-029 NUM_VOICES, PHASE_W, LUT index width (16) and FSM state encodings SHALL live in shared package synth_pkg.
REQ-030 Per-voice phase/incr/gate storage SHALL be sub-module voice_regfile (one write port for config, one read-modify-write port for the sweep); FSM and output registers stay in voice_phase_gen.

Verification
REQ-031 Voice 1 cfg incr=0x0100_0000 gate=1, three ticks -> voice-1 idx = 0x0000, 0x0100, 0x0200; other voices idx=0x0000 idx_gate=0.
REQ-032 Voice 0 incr=0x8000_0000 gate=1, three ticks -> idx 0x0000, 0x8000, 0x0000 (wrap), overrun stays 0.
REQ-033 Voice 2 running at incr=0x0400_0000 for 2 ticks, gate=0 write, 2 ticks -> idx 0x0800 held twice; gate=1 write -> next idx 0x0000.
REQ-034 Second sample_tick 2 cycles after first (NUM_VOICES=4) -> only 4 idx_valid cycles, overrun=1 and stays 1.
REQ-035 cfg_valid=1 in the same cycle as sample_tick -> cfg_ready=0, no write; write accepted next cycle only if FSM in IDLE, else held until sweep ends.
REQ-036 reset_n low during voice 2 of sweep -> idx_valid=0 immediately, all phases 0 after release; next tick yields idx 0x0000 for every voice.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared sizing and FSM encodings for the time-multiplexed voice phase generator.
package synth_pkg;

    localparam int NUM_VOICES = 4;
    localparam int PHASE_W    = 32;
    localparam int IDX_W      = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/voice_regfile.sv
// Per-voice phase/increment/gate storage: a config write port and a sweep
// read-modify-write port that advances the visited voice's phase.
module voice_regfile #(
    parameter  int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter  int PHASE_W    = synth_pkg::PHASE_W,
    localparam int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [VOICE_W-1:0]            wr_voice,
    input  logic [PHASE_W-1:0]            wr_incr,
    input  logic                          wr_gate,
    input  logic                          rmw_en,
    input  logic [VOICE_W-1:0]            rmw_voice,
    output logic [synth_pkg::IDX_W-1:0]   rmw_idx,
    output logic                          rmw_gate
);
    import synth_pkg::*;

    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] incr_q  [NUM_VOICES];
    logic               gate_q  [NUM_VOICES];

    // The sweep sees the pre-increment phase; the update lands at the clock edge.
    assign rmw_idx  = phase_q[rmw_voice][PHASE_W-1 -: IDX_W];
    assign rmw_gate = gate_q[rmw_voice];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                incr_q[v]  <= '0;
                gate_q[v]  <= 1'b0;
            end
        end else begin
            if (rmw_en && gate_q[rmw_voice]) begin
                phase_q[rmw_voice] <= phase_q[rmw_voice] + incr_q[rmw_voice];
            end
            if (wr_en) begin
                incr_q[wr_voice] <= wr_incr;
                gate_q[wr_voice] <= wr_gate;
                // Note-on restarts the phase; a write to an already gated voice glides.
                if (wr_gate && !gate_q[wr_voice]) begin
                    phase_q[wr_voice] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/voice_phase_gen.sv
// Sweeps all voices once per sample tick, emitting each voice's LUT phase index
// and gate one cycle after the voice is visited.
module voice_phase_gen #(
    parameter  int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter  int PHASE_W    = synth_pkg::PHASE_W,
    localparam int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          sample_tick,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [VOICE_W-1:0]            cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_incr,
    input  logic                          cfg_gate,
    output logic                          idx_valid,
    output logic [VOICE_W-1:0]            idx_voice,
    output logic [synth_pkg::IDX_W-1:0]   idx,
    output logic                          idx_gate,
    output logic                          overrun
);
    import synth_pkg::*;

    sweep_state_t         state;
    logic [VOICE_W-1:0]   vcnt;
    logic [IDX_W-1:0]     rmw_idx;
    logic                 rmw_gate;
    logic                 cfg_wr;
    logic                 sweeping;

    // Config is locked out for the whole sweep so every voice sees a consistent snapshot.
    assign cfg_ready = (state == ST_IDLE) && !sample_tick;
    assign cfg_wr    = cfg_valid && cfg_ready;
    assign sweeping  = (state == ST_SWEEP);

    voice_regfile #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (cfg_wr),
        .wr_voice  (cfg_voice),
        .wr_incr   (cfg_incr),
        .wr_gate   (cfg_gate),
        .rmw_en    (sweeping),
        .rmw_voice (vcnt),
        .rmw_idx   (rmw_idx),
        .rmw_gate  (rmw_gate)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            vcnt      <= '0;
            idx_valid <= 1'b0;
            idx_voice <= '0;
            idx       <= '0;
            idx_gate  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            idx_valid <= 1'b0;
            idx_voice <= '0;
            idx       <= '0;
            idx_gate  <= 1'b0;
            if (sample_tick && sweeping) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state <= ST_SWEEP;
                        vcnt  <= '0;
                    end
                end
                ST_SWEEP: begin
                    idx_valid <= 1'b1;
                    idx_voice <= vcnt;
                    idx       <= rmw_idx;
                    idx_gate  <= rmw_gate;
                    if (vcnt == VOICE_W'(NUM_VOICES - 1)) begin
                        state <= ST_IDLE;
                        vcnt  <= '0;
                    end else begin
                        vcnt <= vcnt + VOICE_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_phase_gen.sv
// Self-checking bench: directed table, held-config and overrun/reset sequences,
// plus random traffic against a per-tick snapshot model of the voice bank.
module tb_voice_phase_gen;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [31:0] cfg_incr = '0;
    logic        cfg_gate = 1'b0;
    logic        cfg_ready;
    logic        idx_valid;
    logic [1:0]  idx_voice;
    logic [15:0] idx;
    logic        idx_gate;
    logic        overrun;

    voice_phase_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_voice   (cfg_voice),
        .cfg_incr    (cfg_incr),
        .cfg_gate    (cfg_gate),
        .idx_valid   (idx_valid),
        .idx_voice   (idx_voice),
        .idx         (idx),
        .idx_gate    (idx_gate),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // Reference model: voice bank contents and the schedule of expected outputs.
    typedef struct {
        int          cyc;
        int          voice;
        logic [15:0] idx;
        bit          gate;
    } exp_t;

    logic [31:0] m_phase [N];
    logic [31:0] m_incr  [N];
    bit          m_gate  [N];
    bit          m_ovr;
    bit          m_wrote;
    int          t_start;
    int          cyc;
    exp_t        expq [$];

    int          nvec;
    int          nerr;
    logic [15:0] obs_idx  [N];
    bit          obs_gate [N];
    int          valid_cnt;

    typedef struct {
        bit          is_tick;
        int          voice;
        logic [31:0] incr;
        bit          gate;
        logic [15:0] exp_idx;
        bit          exp_gate;
    } op_t;
    op_t ops [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            m_phase[v] = '0;
            m_incr[v]  = '0;
            m_gate[v]  = 1'b0;
        end
        m_ovr   = 1'b0;
        t_start = -100;
        expq.delete();
    endtask

    task automatic clear_obs();
        for (int v = 0; v < N; v++) begin
            obs_idx[v]  = 16'hDEAD;
            obs_gate[v] = 1'b0;
        end
        valid_cnt = 0;
    endtask

    // One clock cycle: drive inputs, advance the model, check outputs mid-cycle.
    task automatic step(input bit tk, input bit cv, input int vv, input logic [31:0] ci, input bit cg);
        bit   in_sweep;
        bit   exp_rdy;
        bit   have;
        exp_t e;
        @(posedge clock);
        #1;
        sample_tick = tk;
        cfg_valid   = cv;
        cfg_voice   = 2'(vv);
        cfg_incr    = ci;
        cfg_gate    = cg;
        cyc++;
        in_sweep = (cyc >= t_start + 1) && (cyc <= t_start + N);
        exp_rdy  = !in_sweep && !tk;
        m_wrote  = 1'b0;
        if (tk && !in_sweep) begin
            t_start = cyc;
            for (int v = 0; v < N; v++) begin
                e.cyc   = cyc + 2 + v;
                e.voice = v;
                e.idx   = m_phase[v][31:16];
                e.gate  = m_gate[v];
                expq.push_back(e);
                if (m_gate[v]) m_phase[v] = m_phase[v] + m_incr[v];
            end
        end
        if (cv && exp_rdy) begin
            m_wrote = 1'b1;
            if (cg && !m_gate[vv]) m_phase[vv] = '0;
            m_incr[vv] = ci;
            m_gate[vv] = cg;
        end
        @(negedge clock);
        chk("cfg_ready", cfg_ready, exp_rdy);
        chk("overrun", overrun, m_ovr);
        have = (expq.size() > 0) && (expq[0].cyc == cyc);
        if (have) begin
            e = expq.pop_front();
            chk("idx_valid", idx_valid, 1);
            chk("idx_voice", idx_voice, e.voice);
            chk("idx", idx, e.idx);
            chk("idx_gate", idx_gate, e.gate);
        end else begin
            chk("idx_valid_idle", idx_valid, 0);
            chk("idx_voice_idle", idx_voice, 0);
            chk("idx_idle", idx, 0);
            chk("idx_gate_idle", idx_gate, 0);
        end
        if (idx_valid) begin
            obs_idx[idx_voice]  = idx;
            obs_gate[idx_voice] = idx_gate;
            valid_cnt++;
        end
        if (tk && in_sweep) m_ovr = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        int k;
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        model_reset();
        clear_obs();

        ops[0]  = '{0, 1, 32'h0100_0000, 1, 16'h0000, 0};
        ops[1]  = '{1, 1, 32'h0,         0, 16'h0000, 1};
        ops[2]  = '{1, 1, 32'h0,         0, 16'h0100, 1};
        ops[3]  = '{1, 1, 32'h0,         0, 16'h0200, 1};
        ops[4]  = '{1, 3, 32'h0,         0, 16'h0000, 0};
        ops[5]  = '{0, 0, 32'h8000_0000, 1, 16'h0000, 0};
        ops[6]  = '{1, 0, 32'h0,         0, 16'h0000, 1};
        ops[7]  = '{1, 0, 32'h0,         0, 16'h8000, 1};
        ops[8]  = '{1, 0, 32'h0,         0, 16'h0000, 1};
        ops[9]  = '{0, 2, 32'h0400_0000, 1, 16'h0000, 0};
        ops[10] = '{1, 2, 32'h0,         0, 16'h0000, 1};
        ops[11] = '{1, 2, 32'h0,         0, 16'h0400, 1};
        ops[12] = '{0, 2, 32'h0400_0000, 0, 16'h0000, 0};
        ops[13] = '{1, 2, 32'h0,         0, 16'h0800, 0};
        ops[14] = '{1, 2, 32'h0,         0, 16'h0800, 0};
        ops[15] = '{0, 2, 32'h0400_0000, 1, 16'h0000, 0};
        ops[16] = '{1, 2, 32'h0,         0, 16'h0000, 1};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_idx_valid", idx_valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_idx_voice", idx_voice, 0);
        chk("rst_idx_gate", idx_gate, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);

        // Directed table: config writes and per-tick index checks
        for (int i = 0; i < 17; i++) begin
            if (ops[i].is_tick) begin
                clear_obs();
                step(1, 0, 0, 32'h0, 0);
                idle(N + 2);
                chk($sformatf("tbl%0d_idx", i), obs_idx[ops[i].voice], ops[i].exp_idx);
                chk($sformatf("tbl%0d_gate", i), obs_gate[ops[i].voice], ops[i].exp_gate);
                chk($sformatf("tbl%0d_count", i), valid_cnt, N);
            end else begin
                step(0, 1, ops[i].voice, ops[i].incr, ops[i].gate);
                idle(1);
            end
        end

        // Config collides with tick: refused, then held until the sweep ends
        step(1, 1, 3, 32'h0001_0000, 1);
        chk("cfg_tick_refused", m_wrote, 0);
        for (k = 0; k < 20; k++) begin
            step(0, 1, 3, 32'h0001_0000, 1);
            if (m_wrote) break;
        end
        chk("cfg_held_cycles", k, N);
        idle(N + 2);
        clear_obs();
        step(1, 0, 0, 32'h0, 0);
        idle(N + 2);
        chk("held_v3_idx0", obs_idx[3], 16'h0000);
        chk("held_v3_gate", obs_gate[3], 1);
        clear_obs();
        step(1, 0, 0, 32'h0, 0);
        idle(N + 2);
        chk("held_v3_idx1", obs_idx[3], 16'h0001);

        // Random traffic
        for (int r = 0; r < 400; r++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) == 1);
        end
        idle(N + 2);

        // Reset while voice 2 is being visited
        step(1, 0, 0, 32'h0, 0);
        idle(2);
        @(posedge clock);
        #1;
        sample_tick = 1'b0;
        cfg_valid   = 1'b0;
        reset_n     = 1'b0;
        #1;
        chk("midrst_idx_valid", idx_valid, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
        clear_obs();
        idle(6);
        chk("midrst_no_valid", valid_cnt, 0);
        step(1, 0, 0, 32'h0, 0);
        idle(N + 2);
        for (int v = 0; v < N; v++) begin
            chk($sformatf("midrst_v%0d_idx", v), obs_idx[v], 16'h0000);
        end

        // Tick arriving mid-sweep
        clear_obs();
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        idle(N + 4);
        chk("ovr_valid_count", valid_cnt, N);
        chk("ovr_sticky", overrun, 1);
        idle(5);
        chk("ovr_still_set", overrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
